// File: rtl/hb_up2_pkg.sv
// hb_up2_pkg: shared sequencer state encoding and status counter width
package hb_up2_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN_D, RUN_Z, FLUSH} state_t;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating event counter with clear; a coincident event wins over clear (result 1)
// ports: clk, rst_n (async, active-low), clr, inc, cnt
module sat_cnt
  import hb_up2_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= inc ? W'(1) : '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/hb_up2_seq.sv
// hb_up2_seq: zero-stuffing sequencer around an external 2x half-band upsampling filter
// ports: clk, rst_n (async, active-low); enable; s_data/s_valid/s_ready sample input;
//        hb_xin/hb_yout0/hb_yout1/hb_ovf filter link; m_data0/m_data1/m_valid/m_last output pair;
//        busy; ovf_clr/ovf_sticky/ovf_count overflow status; urun_count underruns
module hb_up2_seq
  import hb_up2_pkg::*;
#(
  parameter int XIN_WIDTH   = 16,
  parameter int YOUT_WIDTH  = 16,
  parameter int DUT_LATENCY = 6,
  parameter int FLUSH_PAIRS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [XIN_WIDTH-1:0]  s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [XIN_WIDTH-1:0]  hb_xin,
  input  logic [YOUT_WIDTH-1:0] hb_yout0,
  input  logic [YOUT_WIDTH-1:0] hb_yout1,
  input  logic                  hb_ovf,
  output logic [YOUT_WIDTH-1:0] m_data0,
  output logic [YOUT_WIDTH-1:0] m_data1,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  busy,
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      ovf_count,
  output logic [CNT_W-1:0]      urun_count
);
  localparam int FW = $clog2(2 * FLUSH_PAIRS);
  state_t                 state;
  logic [FW-1:0]          fcnt;
  logic [DUT_LATENCY-1:0] tag_v, tag_l;
  logic                   issue, issue_last, cap, ovf_ev;
  assign s_ready    = state == RUN_D;
  // flush keeps the zero-stuffed cadence: even flush cycles are data phases carrying zero
  assign issue      = s_ready || (state == FLUSH && !fcnt[0]);
  assign issue_last = state == FLUSH && fcnt == FW'(2 * FLUSH_PAIRS - 2);
  // tag leaving the shift register marks the cycle the filter presents that phase's pair
  assign cap        = tag_v[DUT_LATENCY-1];
  assign ovf_ev     = cap && hb_ovf;
  // m_valid term keeps busy high through the final output pair
  assign busy       = (state != IDLE) || (|tag_v) || m_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      fcnt       <= '0;
      tag_v      <= '0;
      tag_l      <= '0;
      hb_xin     <= '0;
      m_data0    <= '0;
      m_data1    <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state   <= (state == IDLE)  ? (enable ? RUN_D : IDLE) :
                 (state == RUN_D) ? RUN_Z :
                 (state == RUN_Z) ? (enable ? RUN_D : FLUSH) :
                 (fcnt == FW'(2 * FLUSH_PAIRS - 1)) ? IDLE : FLUSH;
      fcnt    <= (state == FLUSH) ? fcnt + FW'(1) : '0;
      hb_xin  <= (s_ready && s_valid) ? s_data : '0;
      tag_v   <= (tag_v << 1) | DUT_LATENCY'(issue);
      tag_l   <= (tag_l << 1) | DUT_LATENCY'(issue_last);
      m_valid <= cap;
      m_last  <= tag_l[DUT_LATENCY-1];
      if (cap) begin
        m_data0 <= hb_yout0;
        m_data1 <= hb_yout1;
      end
      if (ovf_ev) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  sat_cnt #(.W(CNT_W)) u_ovf_cnt (
    .clk(clk), .rst_n(rst_n), .clr(ovf_clr), .inc(ovf_ev), .cnt(ovf_count)
  );
  sat_cnt #(.W(CNT_W)) u_urun_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(s_ready && !s_valid), .cnt(urun_count)
  );
endmodule

// File: tb/tb_hb_up2_seq.sv
// tb_hb_up2_seq: directed bench for hb_up2_seq with a scheduling model and a filter stand-in
module tb_hb_up2_seq;
  localparam int L = 6, FP = 8, W = 16;
  logic clk = 0, rst_n = 0, enable = 0, s_valid = 0, ovf_clr = 0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, busy, ovf_sticky, hb_ovf;
  logic [W-1:0] hb_xin, hb_yout0, hb_yout1, m_data0, m_data1;
  logic [15:0] ovf_count, urun_count;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  hb_up2_seq #(.XIN_WIDTH(W), .YOUT_WIDTH(W), .DUT_LATENCY(L), .FLUSH_PAIRS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .hb_xin(hb_xin), .hb_yout0(hb_yout0), .hb_yout1(hb_yout1),
    .hb_ovf(hb_ovf), .m_data0(m_data0), .m_data1(m_data1), .m_valid(m_valid),
    .m_last(m_last), .busy(busy), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
    .ovf_count(ovf_count), .urun_count(urun_count)
  );

  // filter stand-in: the pair for an xin is on hb_yout in the cycle before the sequencer
  // registers it, so m_valid lands L cycles after that xin; 0x7FFF samples report overflow
  logic [W-1:0] xd [L-1] = '{default: '0};
  always @(posedge clk) begin
    xd[0] <= hb_xin;
    for (int i = 1; i < L - 1; i++) xd[i] <= xd[i-1];
  end
  assign hb_yout0 = xd[L-2];
  assign hb_yout1 = xd[L-2] ^ 16'h5A5A;
  assign hb_ovf   = xd[L-2] == 16'h7FFF;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // model: expected hb_xin and output pairs indexed by cycle number
  int cyc = 0, flush_end = -1, last_seen = -10, first_x = -1, mv_cnt = 0;
  logic prev_ready = 0, rec = 0, b_last, b_after;
  logic [W-1:0] xq [int];
  logic [W-1:0] pd [int];
  logic pl [int];
  logic po [int];
  logic [15:0] m_urun = 0, m_cnt = 0;
  logic m_stk = 0;
  int vcyc [$];
  logic [W-1:0] vdat [$];
  logic vlast [$];
  logic [W-1:0] xl [$];

  function automatic void add(input int c, input logic [W-1:0] d, input logic l);
    pd[c] = d;
    pl[c] = l;
    po[c] = d == 16'h7FFF;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      xq.delete(); pd.delete(); pl.delete(); po.delete();
      m_urun = 0; m_cnt = 0; m_stk = 0; prev_ready = 0; flush_end = -1;
      chk("rst_xin", hb_xin, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sready", s_ready, 0);
      chk("rst_urun", urun_count, 0);
      chk("rst_ovf", {ovf_sticky, ovf_count}, 0);
    end else begin
      chk("hb_xin", hb_xin, xq.exists(cyc) ? xq[cyc] : '0);
      chk("m_valid", m_valid, pd.exists(cyc));
      chk("m_last", m_last, pl.exists(cyc) ? pl[cyc] : 1'b0);
      if (pd.exists(cyc)) begin
        chk("m_data0", m_data0, pd[cyc]);
        chk("m_data1", m_data1, pd[cyc] ^ 16'h5A5A);
      end
      chk("urun_count", urun_count, m_urun);
      chk("ovf_sticky", ovf_sticky, m_stk);
      chk("ovf_count", ovf_count, m_cnt);
      if (cyc <= flush_end) begin
        chk("sready_in_flush", s_ready, 0);
        chk("busy_in_flush", busy, 1);
      end
      if (m_valid) begin
        vcyc.push_back(cyc); vdat.push_back(m_data0); vlast.push_back(m_last); mv_cnt++;
      end
      if (m_valid && m_last) begin b_last = busy; last_seen = cyc; end
      if (cyc == last_seen + 1) b_after = busy;
      if (rec) begin
        xl.push_back(hb_xin);
        if (first_x < 0 && hb_xin != 0) first_x = cyc;
      end
      if (s_ready) begin
        xq[cyc+1] = s_valid ? s_data : '0;
        add(cyc + 1 + L, s_valid ? s_data : '0, 1'b0);
        if (!s_valid) m_urun = sat(m_urun);
      end
      // enable low in the zero phase after a data phase starts a flush of FP zero pairs
      if (prev_ready && !enable) begin
        for (int k = 0; k < FP; k++) add(cyc + 2 + 2 * k + L, '0, k == FP - 1);
        flush_end = cyc + 2 * FP;
      end
      if (pd.exists(cyc + 1) && po[cyc+1]) begin
        m_stk = 1;
        m_cnt = ovf_clr ? 16'd1 : sat(m_cnt);
      end else if (ovf_clr) begin
        m_stk = 0; m_cnt = 0;
      end
      prev_ready = s_ready;
    end
    cyc++;
  end

  int nov = 0;
  logic clr_arm = 0;
  logic [W-1:0] tbl [$];

  task automatic tick;
    @(posedge clk); #2;
    ovf_clr = clr_arm && hb_ovf && nov == 2;
    if (hb_ovf) nov++;
  endtask

  task automatic wait_idle(input logic re_en);
    int t = 0;
    do begin
      tick; s_valid = 0; t++;
      if (re_en) enable = t >= 4 && t < 8;
    end while (busy && t < 200);
    enable = 0;
    chk("idle_timeout", busy, 0);
  endtask

  task automatic stream(input int gap, input logic re_en);
    int k = 0, t = 0;
    vcyc.delete(); vdat.delete(); vlast.delete();
    enable = 1;
    while (k < tbl.size() && t < 100) begin
      tick; t++;
      if (s_ready) begin
        s_valid = k != gap; s_data = tbl[k]; k++;
        if (k == tbl.size()) enable = 0;
      end else s_valid = 0;
    end
    chk("stream_issued", k, tbl.size());
    wait_idle(re_en);
  endtask

  logic sc_clk = 0, sc_rst_n = 0, sc_clr = 0, sc_inc = 0;
  logic [15:0] sc_cnt;
  sat_cnt #(.W(16)) u_sat (.clk(sc_clk), .rst_n(sc_rst_n), .clr(sc_clr), .inc(sc_inc), .cnt(sc_cnt));

  task automatic sc_pulse(input int n);
    for (int i = 0; i < n; i++) begin #1 sc_clk = 1; #1 sc_clk = 0; end
  endtask

  initial begin
    logic [W-1:0] xa [7] = '{16'h1000, 0, 16'h2000, 0, 16'h3000, 0, 16'h4000};
    int i0, nl, m0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk("init_busy", busy, 0);
    chk("init_sready", s_ready, 0);
    // continuous stream, zero-stuffed xin, pair cadence and latency
    tbl = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    rec = 1; xl.delete(); first_x = -1;
    stream(-1, 0);
    rec = 0;
    chk("A_pulses", vcyc.size(), 12);
    chk("A_latency", vcyc[0] - first_x, L);
    chk("A_pair_gap", vcyc[1] - vcyc[0], 2);
    i0 = 0;
    while (i0 < xl.size() && xl[i0] == 0) i0++;
    for (int k = 0; k < 7; k++) chk("A_xin_seq", xl[i0+k], xa[k]);
    for (int k = 0; k < 4; k++) chk("A_data", vdat[k], 16'h1000 * (k + 1));
    chk("A_last_final", vlast[11], 1);
    chk("A_last_early", vlast[10], 0);
    // three pairs then flush, enable pulsed during flush is ignored
    tbl = '{16'h0111, 16'h0222, 16'h0333};
    stream(-1, 1);
    chk("B_pulses", vcyc.size(), 11);
    nl = 0;
    foreach (vlast[k]) nl += int'(vlast[k]);
    chk("B_last_count", nl, 1);
    chk("B_last_11th", vlast[10], 1);
    chk("B_busy_at_last", b_last, 1);
    chk("B_busy_after", b_after, 0);
    // one underrun phase
    tbl = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
    stream(1, 0);
    chk("C_urun", urun_count, 1);
    chk("C_gap_data", vdat[1], 0);
    chk("C_after_gap", vdat[2], 16'h0CCC);
    chk("C_cadence", vcyc[3] - vcyc[0], 6);
    // overflow events, clear coincident with the third
    nov = 0; clr_arm = 1;
    tbl = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100};
    stream(-1, 0);
    clr_arm = 0;
    chk("D_ovf_seen", nov, 3);
    chk("D_sticky", ovf_sticky, 1);
    chk("D_count", ovf_count, 1);
    @(posedge clk); #2 ovf_clr = 1;
    @(posedge clk); #2 ovf_clr = 0;
    chk("D_clr_sticky", ovf_sticky, 0);
    chk("D_clr_count", ovf_count, 0);
    // reset with three tags in flight
    begin
      int k = 0, t = 0;
      enable = 1;
      while (k < 3 && t < 50) begin
        tick; t++;
        if (s_ready) begin s_valid = 1; s_data = 16'h0A00 + 16'(k); k++; end
        else s_valid = 0;
      end
    end
    tick;
    #1 rst_n = 0;
    #1;
    chk("E_xin", hb_xin, 0);
    chk("E_mvalid", m_valid, 0);
    chk("E_mdata0", m_data0, 0);
    chk("E_mdata1", m_data1, 0);
    chk("E_busy", busy, 0);
    chk("E_urun", urun_count, 0);
    enable = 0; s_valid = 0;
    #4 rst_n = 1;
    m0 = mv_cnt;
    repeat (30) tick;
    chk("E_no_valid", mv_cnt - m0, 0);
    chk("E_idle", busy, 0);
    // counter saturation on a dedicated instance with its own fast clock
    #1 sc_rst_n = 1; sc_inc = 1;
    sc_pulse(65534);
    chk("F_cnt_fffe", sc_cnt, 16'hFFFE);
    sc_pulse(1);
    chk("F_cnt_ffff", sc_cnt, 16'hFFFF);
    sc_pulse(5);
    chk("F_cnt_hold", sc_cnt, 16'hFFFF);
    sc_clr = 1;
    sc_pulse(1);
    chk("F_clr_inc", sc_cnt, 1);
    sc_inc = 0;
    sc_pulse(1);
    chk("F_clr", sc_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
